// File: rtl/addsub_rr_arbiter_pkg.sv
// Shared constants and helpers for the add/sub round-robin arbiter slice.
package addsub_arb_pkg;

  localparam int DEF_DATAWIDTH    = 8;
  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_PIPE_LATENCY = 4;
  localparam int DEF_MAX_INFLIGHT = DEF_PIPE_LATENCY + 2;

  // Requester id width; never narrower than one bit so a single requester still has a tag.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_rr_arbiter_if.sv
// Request, datapath issue/return and response-broadcast signals of the arbiter.
interface addsub_rr_arbiter_if import addsub_arb_pkg::*; #(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ID_W      = id_width(NUM_REQ)
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*DATAWIDTH-1:0] req_a;
  logic [NUM_REQ*DATAWIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]           req_op;

  logic [DATAWIDTH-1:0]         dp_a;
  logic [DATAWIDTH-1:0]         dp_b;
  logic                         dp_op;
  logic                         dp_valid;

  logic [DATAWIDTH-1:0]         dp_result;
  logic                         dp_carry;
  logic                         dp_rsp_valid;

  logic                         rsp_valid;
  logic [ID_W-1:0]              rsp_id;
  logic [DATAWIDTH-1:0]         rsp_result;
  logic                         rsp_carry;

  logic                         busy;
  logic                         err_unexpected;

  // Environment side: requesters plus the shared datapath.
  modport master (
    output req_valid, req_a, req_b, req_op,
    output dp_result, dp_carry, dp_rsp_valid,
    input  req_ready, dp_a, dp_b, dp_op, dp_valid,
    input  rsp_valid, rsp_id, rsp_result, rsp_carry, busy, err_unexpected
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, req_op,
    input  dp_result, dp_carry, dp_rsp_valid,
    output req_ready, dp_a, dp_b, dp_op, dp_valid,
    output rsp_valid, rsp_id, rsp_result, rsp_carry, busy, err_unexpected
  );

endinterface

// File: rtl/addsub_rr_arbiter_tag_fifo.sv
// Tag FIFO holding requester ids of operations in flight through the datapath.
module addsub_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 6,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; depth need not be a power of two, so wrap explicitly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined adder-subtractor among NUM_REQ requesters.
module addsub_rr_arbiter import addsub_arb_pkg::*; #(
  parameter int DATAWIDTH    = DEF_DATAWIDTH,
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int PIPE_LATENCY = DEF_PIPE_LATENCY,
  parameter int MAX_INFLIGHT = PIPE_LATENCY + 2
) (
  input logic                clk,
  input logic                rst,
  addsub_rr_arbiter_if.slave bus
);

  localparam int              ID_W      = id_width(NUM_REQ);
  localparam int              CNT_W     = $clog2(MAX_INFLIGHT + 1);
  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W:0]    scan;
  logic             grant_ok;
  logic [ID_W-1:0]  grant_idx;
  logic             hs;
  logic             pop;
  logic [ID_W-1:0]  pop_tag;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] inflight;

  // First valid requester at or after rr_ptr; scan downward so the nearest one is written last.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      scan = {1'b0, rr_ptr} + (ID_W + 1)'(j);
      if (scan >= NUM_REQ_W) scan = scan - NUM_REQ_W;
      if (bus.req_valid[scan[ID_W-1:0]]) begin
        grant_ok  = 1'b1;
        grant_idx = scan[ID_W-1:0];
      end
    end
  end

  // Ready is gated by the in-flight limit only, never by a same-cycle return.
  assign hs = grant_ok && !fifo_full && !rst;

  // One-hot ready to the winner when the grant can be taken.
  always_comb begin
    bus.req_ready = '0;
    if (hs) bus.req_ready[grant_idx] = 1'b1;
  end

  assign pop      = bus.dp_rsp_valid && !fifo_empty;
  assign bus.busy = (inflight != '0);

  addsub_tag_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (hs),
    .push_data (grant_idx),
    .pop       (pop),
    .pop_data  (pop_tag),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (inflight)
  );

  // Issue the winner's operands, advance the pointer, and broadcast tagged results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr             <= '0;
      bus.dp_valid       <= 1'b0;
      bus.dp_a           <= '0;
      bus.dp_b           <= '0;
      bus.dp_op          <= 1'b0;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_id         <= '0;
      bus.rsp_result     <= '0;
      bus.rsp_carry      <= 1'b0;
      bus.err_unexpected <= 1'b0;
    end else begin
      bus.dp_valid  <= hs;
      bus.rsp_valid <= pop;
      if (hs) begin
        rr_ptr     <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        bus.dp_a   <= bus.req_a[grant_idx*DATAWIDTH +: DATAWIDTH];
        bus.dp_b   <= bus.req_b[grant_idx*DATAWIDTH +: DATAWIDTH];
        bus.dp_op  <= bus.req_op[grant_idx];
      end
      if (pop) begin
        bus.rsp_id     <= pop_tag;
        bus.rsp_result <= bus.dp_result;
        bus.rsp_carry  <= bus.dp_carry;
      end
      // A return with no tag outstanding is stale or spurious; it is only recorded.
      if (bus.dp_rsp_valid && fifo_empty) bus.err_unexpected <= 1'b1;
    end
  end

endmodule
